// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver: receive state
//                enumeration, default frame geometry and the idle line level.
//                The PARITY state exists only when UART_RX_PARITY_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int   c_OVERSAMPLE_DEF = 8;     // clk cycles per bit
    localparam int   c_DATA_WIDTH_DEF = 8;     // payload bits per frame
    localparam logic c_LINE_IDLE      = 1'b1;  // serial line level between frames

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Per-bit oversample counter, three-sample majority vote and
//                bit-end strobe for the UART receiver.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                i_rx          serial line
//                i_start       idle line seen low this clk (count 0 of start)
//                i_busy        receiver is inside a frame
//                o_bit         voted bit value, valid at the bit-end strobe
//                o_bit_end     high on count OVERSAMPLE-1 of every bit
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    input  logic i_start,
    input  logic i_busy,
    output logic o_bit,
    output logic o_bit_end
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_CNT_W-1:0] c_S0       = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_S1       = c_CNT_W'(OVERSAMPLE / 2);
    localparam logic [c_CNT_W-1:0] c_S2       = c_CNT_W'(OVERSAMPLE / 2 + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_s0;
    logic               r_s1;
    logic               r_vote;
    logic               w_vote_now;

    // Majority of the two stored samples and the live third one.
    assign w_vote_now = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_vote <= 1'b0;
        end else begin
            if (i_busy) begin
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end else if (i_start) begin
                // The detecting clk already was count 0 of the start bit.
                r_cnt <= c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (i_busy && r_cnt == c_S0) r_s0   <= i_rx;
            if (i_busy && r_cnt == c_S1) r_s1   <= i_rx;
            if (i_busy && r_cnt == c_S2) r_vote <= w_vote_now;
        end
    end

    // With OVERSAMPLE=4 the last sample coincides with the bit end, so the
    // vote is forwarded combinationally on that count.
    assign o_bit     = (r_cnt == c_S2) ? w_vote_now : r_vote;
    assign o_bit_end = i_busy && (r_cnt == c_CNT_LAST);

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Frame = start, DATA_WIDTH data
//                bits LSB first, optional parity bit, one stop bit.
//                Optional feature macro: UART_RX_PARITY_EN (adds the PARITY
//                state, the PAR_TYP input and parity_error logic).
//  Ports       : clk            OVERSAMPLE x baud clock
//                rst            synchronous active-high reset
//                RX_IN          serial line, idle high, pre-synchronized
//                PAR_TYP        1 = odd, 0 = even (parity build only)
//                P_DATA         last good received word
//                data_valid     one-clk pulse when P_DATA updates
//                framing_error  one-clk pulse, stop bit sampled low
//                parity_error   one-clk pulse, parity mismatch (0 if no parity)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = c_OVERSAMPLE_DEF,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
`ifdef UART_RX_PARITY_EN
    input  logic                  PAR_TYP,
`endif
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  framing_error,
    output logic                  parity_error
);

    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);

    uart_state_e           r_state;
    uart_state_e           w_state_nxt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic [DATA_WIDTH:0]   w_shift_in;
    logic                  r_pend;      // stop bit just ended, report next clk
    logic                  r_stop_ok;
    logic                  r_par_ok;
    logic                  r_dv;
    logic                  r_ferr;
    logic                  w_par_ok;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_bit;
    logic                  w_bit_end;

    assign w_busy  = (r_state != IDLE);
    assign w_start = (r_state == IDLE) && (RX_IN != c_LINE_IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .i_rx      (RX_IN),
        .i_start   (w_start),
        .i_busy    (w_busy),
        .o_bit     (w_bit),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start) w_state_nxt = START;
            // A start bit that votes high was a glitch.
            START: if (w_bit_end) w_state_nxt = w_bit ? IDLE : DATA;
            DATA:  if (w_bit_end && r_idx == c_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                       w_state_nxt = PARITY;
`else
                       w_state_nxt = STOP;
`endif
                   end
`ifdef UART_RX_PARITY_EN
            PARITY: if (w_bit_end) w_state_nxt = STOP;
`endif
            STOP:  if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_shift_in = {w_bit, r_shift};

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_perr;

    // Received parity bit must equal XOR of data, inverted for odd parity.
    assign w_par_ok = (r_par_bit == (^r_shift ^ PAR_TYP));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == PARITY && w_bit_end) r_par_bit <= w_bit;
            r_perr <= r_pend & ~r_par_ok;
        end
    end

    assign parity_error = r_perr;
`else
    assign w_par_ok     = 1'b1;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_shift   <= '0;
            r_pend    <= 1'b0;
            r_stop_ok <= 1'b0;
            r_par_ok  <= 1'b0;
            r_p_data  <= '0;
            r_dv      <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_pend <= 1'b0;
            if (r_state == DATA && w_bit_end) begin
                r_shift <= w_shift_in[DATA_WIDTH:1];
                r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (r_state == STOP && w_bit_end) begin
                r_pend    <= 1'b1;
                r_stop_ok <= w_bit;
                r_par_ok  <= w_par_ok;
            end
            r_dv   <= r_pend & r_stop_ok & r_par_ok;
            r_ferr <= r_pend & ~r_stop_ok;
            if (r_pend && r_stop_ok && r_par_ok) r_p_data <= r_shift;
        end
    end

    assign P_DATA        = r_p_data;
    assign data_valid    = r_dv;
    assign framing_error = r_ferr;

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 8, meaning clk cycles per bit (even, 4..32).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-003 SHALL have port clk  input  1  the single clock, running at OVERSAMPLE x baud.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, already synchronized upstream.
REQ-006 SHALL have port P_DATA  output  DATA_WIDTH  last good received word, LSB first on the line.
REQ-007 SHALL have port data_valid  output  1  one-clk pulse when P_DATA is updated.
REQ-008 SHALL have port framing_error  output  1  one-clk pulse when a stop bit is sampled low.
REQ-009 SHALL have port parity_error  output  1  one-clk pulse on a parity mismatch; tied 0 when parity is compiled out.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-011 IDLE -> START on the first clk with RX_IN=0; that clk is sample count 0 of the start bit.
REQ-012 Each bit SHALL span OVERSAMPLE clks (count 0..OVERSAMPLE-1); the bit value is the majority of samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-013 A START vote of 1 is a glitch: return to IDLE at the end of that count with no flag.
REQ-014 START(vote 0) -> DATA at the bit end; DATA shifts DATA_WIDTH voted bits LSB first into a shift register separate from P_DATA.
REQ-015 DATA -> PARITY (macro defined) or STOP (macro undefined) after bit DATA_WIDTH-1 ends.
REQ-016 At the STOP bit end: if stop=1 and no parity error, P_DATA <= shift register and data_valid=1 on the next clk.
REQ-017 If stop=0, framing_error SHALL pulse instead, data_valid SHALL stay 0 and P_DATA SHALL hold its old value.
REQ-018 If parity fails and stop=1, parity_error SHALL pulse, data_valid SHALL stay 0 and P_DATA SHALL hold; if both fail, both errors SHALL pulse together.
REQ-019 STOP -> IDLE at the bit end; a low RX_IN on the very next clk SHALL start a new frame (back-to-back frames, zero gap).
REQ-020 Frame latency: data_valid at clk 10*OVERSAMPLE (no parity) or 11*OVERSAMPLE (parity) counted from the first low sample at clk 0.
REQ-021 RX_IN edges in mid-frame SHALL NOT resynchronize the bit counter.

Reset
REQ-022 With rst=1 at a clk edge: state=IDLE, counters=0, shift register=0, P_DATA=0, data_valid=0, framing_error=0, parity_error=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no flag pulses; reception restarts on the first low sample after rst deasserts.

Configuration
REQ-024 Macro UART_RX_PARITY_EN SHALL compile in a PARITY state, input PAR_TYP (1=odd, 0=even) and the parity_error logic.
REQ-025 Without UART_RX_PARITY_EN: no PARITY state, no PAR_TYP port, and parity_error is a constant 0.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, the default OVERSAMPLE and DATA_WIDTH, and the IDLE line level constant.
REQ-027 Sub-module uart_rx_sampler SHALL hold the oversample counter, the three-sample majority vote and the bit-end strobe; the FSM, shifting and checking stay in uart_rx.

Verification
REQ-028 Frame 8'h8F, no parity -> P_DATA=8'h8F, data_valid pulses once at clk 80, no error flags.
REQ-029 Frame 8'h9E immediately followed by 8'h3C, zero gap -> two data_valid pulses at clk 80 and clk 160 with values 9E then 3C.
REQ-030 RX_IN low for 2 clks then high -> no state leaves IDLE past START, no pulses, P_DATA unchanged.
REQ-031 Frame 8'h55 with stop bit low -> framing_error pulses at clk 80, data_valid=0, P_DATA keeps its prior value.
REQ-032 With UART_RX_PARITY_EN, PAR_TYP=0, 8'hA5 sent with parity bit 1 -> parity_error pulses at clk 88; with correct parity bit 0 -> data_valid pulses at clk 88 with P_DATA=8'hA5.
REQ-033 rst pulsed at clk 40 of a frame -> all outputs 0 on the next clk, no pulses; the following clean frame 8'h12 is received correctly.
